// File: rtl/vc_credit_if.sv
// Credit return channel: one message per handshake carrying a VC index and a word count.
interface vc_credit_if #(
  parameter int NUM_VCS     = 2,
  parameter int BUFFER_SIZE = 8
);
  localparam int CW = $clog2(BUFFER_SIZE + 1);
  localparam int VW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

  logic          credit_valid;
  logic          credit_ready;
  logic [VW-1:0] credit_vc;
  logic [CW-1:0] credit_count;

  modport master (
    output credit_valid,
    output credit_vc,
    output credit_count,
    input  credit_ready
  );

  modport slave (
    input  credit_valid,
    input  credit_vc,
    input  credit_count,
    output credit_ready
  );
endinterface

// File: rtl/vc_credit_returner.sv
// Counts words drained from each VC buffer and returns them upstream as batched,
// round-robin-arbitrated credit messages over a registered valid/ready slot.
module vc_credit_returner #(
  parameter int NUM_VCS     = 2,
  parameter int BUFFER_SIZE = 8,
  localparam int CW = $clog2(BUFFER_SIZE + 1),
  localparam int VW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_VCS-1:0]    word_consumed,
  vc_credit_if.master           credit,
  output logic [NUM_VCS*CW-1:0] pending,
  output logic                  overflow_err
);

  logic [CW-1:0] pend_q [NUM_VCS];
  logic [CW-1:0] pend_d [NUM_VCS];
  logic          valid_q, valid_d;
  logic [VW-1:0] vc_q, vc_d;
  logic [CW-1:0] count_q, count_d;
  logic [VW-1:0] rr_q, rr_d;
  logic          ovf_q, ovf_d;

  logic [NUM_VCS-1:0] nz;
  logic [NUM_VCS-1:0] sat;
  logic               slot_free;
  logic               load;
  logic [VW-1:0]      sel;

  generate
    for (genvar gi = 0; gi < NUM_VCS; gi++) begin : g_vc
      assign nz[gi]                 = (pend_q[gi] != '0);
      assign pending[gi*CW +: CW]   = pend_q[gi];
    end
  endgenerate

  assign slot_free = !valid_q || credit.credit_ready;
  assign load      = slot_free && (|nz);

  // Scan from farthest to nearest so the nearest non-empty VC after rr wins.
  always_comb begin
    int idx;
    idx = 0;
    sel = rr_q;
    for (int k = NUM_VCS; k >= 1; k--) begin
      idx = (int'(rr_q) + k) % NUM_VCS;
      if (nz[idx]) sel = VW'(idx);
    end
  end

  // A load drains the registered count; a same-cycle consume survives on top.
  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      pend_d[v] = pend_q[v];
      sat[v]    = 1'b0;
      if (load && (sel == VW'(v))) pend_d[v] = '0;
      if (word_consumed[v]) begin
        if (pend_d[v] == CW'(BUFFER_SIZE)) sat[v] = 1'b1;
        else                               pend_d[v] = pend_d[v] + CW'(1);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    vc_d    = vc_q;
    count_d = count_q;
    rr_d    = rr_q;
    ovf_d   = ovf_q | (|sat);
    if (load) begin
      valid_d = 1'b1;
      vc_d    = sel;
      count_d = pend_q[sel];
      rr_d    = sel;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VCS; v++) pend_q[v] <= '0;
      valid_q <= 1'b0;
      vc_q    <= '0;
      count_q <= '0;
      rr_q    <= VW'(NUM_VCS - 1);
      ovf_q   <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) pend_q[v] <= pend_d[v];
      valid_q <= valid_d;
      vc_q    <= vc_d;
      count_q <= count_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign credit.credit_valid = valid_q;
  assign credit.credit_vc    = vc_q;
  assign credit.credit_count = count_q;
  assign overflow_err        = ovf_q;

endmodule

// File: tb/tb_vc_credit_returner.sv
// Randomized and directed bench for vc_credit_returner against an integer reference model.
module tb_vc_credit_returner;
  localparam int NV = 4;
  localparam int BS = 4;
  localparam int CW = $clog2(BS + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic [NV-1:0]      word_consumed;
  logic [NV*CW-1:0]   pending;
  logic               overflow_err;

  vc_credit_if #(.NUM_VCS(NV), .BUFFER_SIZE(BS)) cif ();

  vc_credit_returner #(.NUM_VCS(NV), .BUFFER_SIZE(BS)) dut (
    .clk          (clk),
    .rst          (rst),
    .word_consumed(word_consumed),
    .credit       (cif.master),
    .pending      (pending),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: integer pending counts, one output slot, rotating pointer.
  int  m_pend [NV];
  bit  m_valid;
  int  m_vc, m_cnt, m_rr;
  bit  m_ovf;
  bit  chk_en = 1'b0;

  always @(posedge clk) begin : model
    int sel, idx;
    bit free;
    int nxt [NV];
    if (rst) begin
      foreach (m_pend[v]) m_pend[v] = 0;
      m_valid = 0; m_vc = 0; m_cnt = 0; m_rr = NV - 1; m_ovf = 0;
    end else begin
      free = !m_valid || cif.credit_ready;
      sel  = -1;
      if (free)
        for (int k = 1; k <= NV; k++) begin
          idx = (m_rr + k) % NV;
          if (sel < 0 && m_pend[idx] > 0) sel = idx;
        end
      for (int v = 0; v < NV; v++) begin
        nxt[v] = (v == sel) ? 0 : m_pend[v];
        if (word_consumed[v]) begin
          if (nxt[v] >= BS) m_ovf = 1;
          else              nxt[v] = nxt[v] + 1;
        end
      end
      if (sel >= 0) begin
        m_valid = 1; m_vc = sel; m_cnt = m_pend[sel]; m_rr = sel;
      end else if (free) begin
        m_valid = 0;
      end
      m_pend = nxt;
    end
  end

  // Per-cycle compare plus accounting of credits the upstream actually accepted.
  int dut_acc [NV];
  int log_vc [$];
  int log_cnt [$];
  bit log_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("credit_valid", int'(cif.credit_valid), int'(m_valid));
      if (m_valid) begin
        chk("credit_vc", int'(cif.credit_vc), m_vc);
        chk("credit_count", int'(cif.credit_count), m_cnt);
      end
      for (int v = 0; v < NV; v++)
        chk($sformatf("pending%0d", v), int'(pending[v*CW +: CW]), m_pend[v]);
      chk("overflow_err", int'(overflow_err), int'(m_ovf));
    end
    if (rst) begin
      foreach (dut_acc[v]) dut_acc[v] = 0;
    end else if (cif.credit_valid && cif.credit_ready) begin
      dut_acc[cif.credit_vc] += int'(cif.credit_count);
      if (log_en) begin
        log_vc.push_back(int'(cif.credit_vc));
        log_cnt.push_back(int'(cif.credit_count));
      end
    end
  end

  int cons [NV];

  task automatic cyc(input logic [NV-1:0] wc, input logic rd);
    word_consumed     = wc;
    cif.credit_ready  = rd;
    if (!rst)
      for (int v = 0; v < NV; v++) if (wc[v]) cons[v]++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc('0, 1'b0);
    cyc('0, 1'b0);
    rst = 1'b0;
    foreach (cons[v]) cons[v] = 0;
    chk_en = 1'b1;
  endtask

  task automatic expect_msg(input string name, input int valid, input int vc, input int cnt);
    chk({name, ".valid"}, int'(cif.credit_valid), valid);
    if (valid != 0) begin
      chk({name, ".vc"}, int'(cif.credit_vc), vc);
      chk({name, ".count"}, int'(cif.credit_count), cnt);
    end
  endtask

  function automatic int pend_of(input int v);
    return int'(pending[v*CW +: CW]);
  endfunction

  initial begin
    logic [NV-1:0] wc;
    rst = 1'b1;
    word_consumed = '0;
    cif.credit_ready = 1'b0;

    // Reset and idle: every output must read zero.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      chk("idle.valid", int'(cif.credit_valid), 0);
      chk("idle.vc", int'(cif.credit_vc), 0);
      chk("idle.count", int'(cif.credit_count), 0);
      chk("idle.pending", int'(pending), 0);
      chk("idle.overflow", int'(overflow_err), 0);
      cyc('0, 1'b0);
    end

    // Single word on VC0.
    cyc(4'b0001, 1'b1);
    chk("single.pending0_c1", pend_of(0), 1);
    expect_msg("single.c1", 0, 0, 0);
    cyc('0, 1'b1);
    expect_msg("single.c2", 1, 0, 1);
    cyc('0, 1'b1);
    expect_msg("single.c3", 0, 0, 0);

    // Batching under backpressure on VC1.
    do_reset();
    cyc(4'b0010, 1'b0);
    cyc(4'b0010, 1'b0);
    expect_msg("batch.c2", 1, 1, 1);
    repeat (3) cyc(4'b0010, 1'b0);
    expect_msg("batch.c5_held", 1, 1, 1);
    chk("batch.pending1_c5", pend_of(1), 4);
    cyc('0, 1'b0);
    cyc('0, 1'b1);
    expect_msg("batch.c7", 1, 1, 4);
    chk("batch.pending1_c7", pend_of(1), 0);
    cyc('0, 1'b1);
    expect_msg("batch.c8", 0, 0, 0);

    // Load and consume on the same VC at the same edge.
    do_reset();
    cyc(4'b0010, 1'b0);
    repeat (3) cyc(4'b0001, 1'b0);
    chk("simul.pending0_c4", pend_of(0), 3);
    expect_msg("simul.c4", 1, 1, 1);
    cyc(4'b0001, 1'b1);
    expect_msg("simul.c5", 1, 0, 3);
    chk("simul.pending0_c5", pend_of(0), 1);
    repeat (4) cyc('0, 1'b1);

    // Round-robin fairness with every VC consuming each cycle.
    do_reset();
    log_en = 1'b1;
    repeat (40) cyc('1, 1'b1);
    log_en = 1'b0;
    chk("rr.msgs_ge_30", int'(log_vc.size() >= 30), 1);
    if (log_vc.size() >= 5) begin
      chk("rr.m0_vc", log_vc[0], 0); chk("rr.m0_cnt", log_cnt[0], 1);
      chk("rr.m1_vc", log_vc[1], 1); chk("rr.m1_cnt", log_cnt[1], 2);
      chk("rr.m2_vc", log_vc[2], 2); chk("rr.m2_cnt", log_cnt[2], 3);
      chk("rr.m3_vc", log_vc[3], 3); chk("rr.m3_cnt", log_cnt[3], 4);
      chk("rr.m4_vc", log_vc[4], 0); chk("rr.m4_cnt", log_cnt[4], 4);
    end
    for (int i = 0; i < log_vc.size(); i++)
      chk($sformatf("rr.seq%0d", i), log_vc[i], i % NV);
    repeat (10) cyc('0, 1'b1);
    for (int v = 0; v < NV; v++) begin
      chk($sformatf("rr.sum_vc%0d", v), dut_acc[v], cons[v]);
      chk($sformatf("rr.cons_vc%0d", v), cons[v], 40);
    end
    chk("rr.drained", int'(pending), 0);

    // Random traffic that respects the per-VC buffer invariant.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int v = 0; v < NV; v++) begin
        int inflight;
        inflight = (m_valid && m_vc == v) ? m_cnt : 0;
        wc[v] = ($urandom_range(0, 2) == 0) && (m_pend[v] + inflight < BS);
      end
      cyc(wc, ($urandom_range(0, 3) != 0));
    end
    repeat (12) cyc('0, 1'b1);
    for (int v = 0; v < NV; v++)
      chk($sformatf("rand.sum_vc%0d", v), dut_acc[v], cons[v]);
    chk("rand.drained_valid", int'(cif.credit_valid), 0);
    chk("rand.drained_pending", int'(pending), 0);
    chk("rand.no_overflow", int'(overflow_err), 0);

    // Overflow: six words on VC0 with upstream stalled.
    do_reset();
    repeat (6) cyc(4'b0001, 1'b0);
    chk("ovf.pending0", pend_of(0), BS);
    chk("ovf.flag", int'(overflow_err), 1);
    expect_msg("ovf.held", 1, 0, 1);
    repeat (3) cyc('0, 1'b0);
    chk("ovf.sticky", int'(overflow_err), 1);
    do_reset();
    chk("ovf.cleared", int'(overflow_err), 0);
    chk("ovf.pending_cleared", int'(pending), 0);
    chk("ovf.valid_cleared", int'(cif.credit_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
